cpu_duv_trace_buf: RTL and testbench

- Parametrised bus-trace capture buffer instantiated beside the CPU inside the DUV top.
- Snoops every CPU bus access (address, data, read/write) and stamps each with a free-running cycle timestamp.
- Three capture modes: free-run, start-on-trigger, and fixed post-trigger window.
- Stores entries in a first-word-fall-through FIFO that the testbench drains over a valid/ready handshake.

---
 rtl/cpu_duv_trace_buf.sv | 177 +++++++++++++++++
 tb/tb_cpu_duv_trace_buf.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_duv_trace_buf.sv
// Bus-trace capture buffer that sits beside the CPU inside the DUV top.
// Snoops CPU bus accesses, stamps each one with a cycle timestamp and queues
// it in a first-word-fall-through FIFO drained over a valid/ready handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | capture off, timestamp held at 0, FIFO can still be drained
// ARMED    | waiting for an access to i_trig_addr (mode 1 only)
// CAPTURE  | every strobe is pushed; mode 2 counts down its window
// DONE     | mode 2 window exhausted, strobes ignored until cap_en drops
module cpu_duv_trace_buf #(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int DEPTH    = 64,
   parameter int TSW      = 16,
   parameter int POST_CNT = 32
) (
   input  logic                       i_clk,
   input  logic                       i_b_rst,
   input  logic                       i_cap_en,
   input  logic [1:0]                 i_trig_mode,
   input  logic [AW-1:0]              i_trig_addr,
   input  logic                       i_cpu_strobe,
   input  logic [AW-1:0]              i_cpu_addr,
   input  logic [DW-1:0]              i_cpu_data,
   input  logic                       i_cpu_rw,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [AW-1:0]              o_out_addr,
   output logic [DW-1:0]              o_out_data,
   output logic                       o_out_rw,
   output logic [TSW-1:0]             o_out_ts,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow,
   output logic [1:0]                 o_state
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int KW = $clog2(POST_CNT + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_win_mode;
   logic [KW-1:0]   r_post_left;
   logic [TSW-1:0]  r_ts;
   logic            r_overflow;

   logic [AW-1:0]   r_mem_addr [DEPTH];
   logic [DW-1:0]   r_mem_data [DEPTH];
   logic            r_mem_rw   [DEPTH];
   logic [TSW-1:0]  r_mem_ts   [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_trig_hit;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_wr;
   logic            w_drop;

   assign w_trig_hit = i_cpu_strobe && (i_cpu_addr == i_trig_addr);
   // cap_en low wins over capture: a strobe in the drop-to-IDLE cycle is lost.
   assign w_push     = i_cap_en &&
                       (((r_state == ST_CAPTURE) && i_cpu_strobe) ||
                        ((r_state == ST_ARMED) && w_trig_hit));
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   // On an empty FIFO a same-cycle push cannot be popped; the head is not valid yet.
   assign w_pop      = !w_empty && i_out_ready;
   assign w_wr       = w_push && (!w_full || w_pop);
   assign w_drop     = w_push && w_full && !w_pop;

   assign o_out_valid = !w_empty;
   assign o_out_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr];
   assign o_out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
   assign o_out_rw    = w_empty ? 1'b0 : r_mem_rw[r_rd_ptr];
   assign o_out_ts    = w_empty ? '0 : r_mem_ts[r_rd_ptr];
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_state     = r_state;

   // Capture sequencing; trig_mode is latched only when leaving IDLE.
   always_ff @(posedge i_clk or negedge i_b_rst) begin
      if (!i_b_rst) begin
         r_state     <= ST_IDLE;
         r_win_mode  <= 1'b0;
         r_post_left <= '0;
      end else if (!i_cap_en) begin
         r_state     <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_win_mode  <= (i_trig_mode == 2'd2);
               r_post_left <= KW'(POST_CNT);
               r_state     <= (i_trig_mode == 2'd1) ? ST_ARMED : ST_CAPTURE;
            end
            ST_ARMED: begin
               if (w_trig_hit) begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               // Window counts strobes whether they were stored or dropped.
               if (r_win_mode && i_cpu_strobe) begin
                  r_post_left <= r_post_left - KW'(1);
                  if (r_post_left == KW'(1)) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            default: begin
               r_state <= ST_DONE;
            end
         endcase
      end
   end

   // Free-running timestamp, held at zero whenever the next state is IDLE or we are in IDLE.
   always_ff @(posedge i_clk or negedge i_b_rst) begin
      if (!i_b_rst) begin
         r_ts <= '0;
      end else if (!i_cap_en || (r_state == ST_IDLE)) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + TSW'(1);
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_b_rst) begin
      if (!i_b_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_addr[i] <= '0;
            r_mem_data[i] <= '0;
            r_mem_rw[i]   <= 1'b0;
            r_mem_ts[i]   <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_mem_addr[r_wr_ptr] <= i_cpu_addr;
            r_mem_data[r_wr_ptr] <= i_cpu_data;
            r_mem_rw[r_wr_ptr]   <= i_cpu_rw;
            r_mem_ts[r_wr_ptr]   <= r_ts;
            r_wr_ptr             <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      end
   end

   // Sticky overflow, cleared when a new capture session starts.
   always_ff @(posedge i_clk or negedge i_b_rst) begin
      if (!i_b_rst) begin
         r_overflow <= 1'b0;
      end else if (i_cap_en && (r_state == ST_IDLE)) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_duv_trace_buf.sv
// Directed bench for the trace buffer: small FIFO (4) and short window (4).
module tb_cpu_duv_trace_buf;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int TSW = 16;
   localparam int POST_CNT = 4;
   localparam int CW = $clog2(DEPTH + 1);

   logic           clk;
   logic           b_rst;
   logic           cap_en;
   logic [1:0]     trig_mode;
   logic [AW-1:0]  trig_addr;
   logic           cpu_strobe;
   logic [AW-1:0]  cpu_addr;
   logic [DW-1:0]  cpu_data;
   logic           cpu_rw;
   logic           out_valid;
   logic           out_ready;
   logic [AW-1:0]  out_addr;
   logic [DW-1:0]  out_data;
   logic           out_rw;
   logic [TSW-1:0] out_ts;
   logic [CW-1:0]  count;
   logic           overflow;
   logic [1:0]     state;

   int n_chk;
   int n_err;
   int seen;

   cpu_duv_trace_buf #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .TSW(TSW), .POST_CNT(POST_CNT)
   ) dut (
      .i_clk(clk),
      .i_b_rst(b_rst),
      .i_cap_en(cap_en),
      .i_trig_mode(trig_mode),
      .i_trig_addr(trig_addr),
      .i_cpu_strobe(cpu_strobe),
      .i_cpu_addr(cpu_addr),
      .i_cpu_data(cpu_data),
      .i_cpu_rw(cpu_rw),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_out_addr(out_addr),
      .o_out_data(out_data),
      .o_out_rw(out_rw),
      .o_out_ts(out_ts),
      .o_count(count),
      .o_overflow(overflow),
      .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
      cpu_strobe = 1'b1;
      cpu_addr   = a;
      cpu_data   = d;
      cpu_rw     = rw;
      step();
      cpu_strobe = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      b_rst = 1'b0;
      cap_en = 1'b0;
      trig_mode = 2'd0;
      trig_addr = '0;
      cpu_strobe = 1'b0;
      cpu_addr = '0;
      cpu_data = '0;
      cpu_rw = 1'b0;
      out_ready = 1'b0;
      #12;
      chk_eq("rst_state", 32'(state), 0);
      chk_eq("rst_count", 32'(count), 0);
      chk_eq("rst_valid", 32'(out_valid), 0);
      chk_eq("rst_addr", 32'(out_addr), 0);
      chk_eq("rst_ts", 32'(out_ts), 0);
      chk_eq("rst_ovf", 32'(overflow), 0);
      b_rst = 1'b1;
      step();

      // Free-run: strobes at ts 0, 1, 3
      trig_mode = 2'd0;
      out_ready = 1'b1;
      cap_en = 1'b1;
      step();
      chk_eq("fr_state", 32'(state), 2);
      strobe_step(16'h8000, 8'h11, 1'b1);
      chk_eq("fr_e0_valid", 32'(out_valid), 1);
      chk_eq("fr_e0_addr", 32'(out_addr), 32'h8000);
      chk_eq("fr_e0_ts", 32'(out_ts), 0);
      chk_eq("fr_e0_rw", 32'(out_rw), 1);
      chk_eq("fr_e0_data", 32'(out_data), 32'h11);
      strobe_step(16'h8001, 8'h22, 1'b1);
      chk_eq("fr_e1_addr", 32'(out_addr), 32'h8001);
      chk_eq("fr_e1_ts", 32'(out_ts), 1);
      chk_eq("fr_e1_count", 32'(count), 1);
      step();
      chk_eq("fr_gap_valid", 32'(out_valid), 0);
      strobe_step(16'h0200, 8'h33, 1'b0);
      chk_eq("fr_e2_addr", 32'(out_addr), 32'h0200);
      chk_eq("fr_e2_ts", 32'(out_ts), 3);
      chk_eq("fr_e2_rw", 32'(out_rw), 0);
      step();
      chk_eq("fr_count0", 32'(count), 0);
      chk_eq("fr_state_end", 32'(state), 2);
      cap_en = 1'b0;
      step();
      chk_eq("fr_idle", 32'(state), 0);

      // Start-on-trigger
      trig_mode = 2'd1;
      trig_addr = 16'hFFFC;
      out_ready = 1'b0;
      cap_en = 1'b1;
      step();
      chk_eq("tr_armed", 32'(state), 1);
      strobe_step(16'h0000, 8'h01, 1'b1);
      chk_eq("tr_s0_state", 32'(state), 1);
      chk_eq("tr_s0_count", 32'(count), 0);
      strobe_step(16'h0001, 8'h02, 1'b1);
      chk_eq("tr_s1_state", 32'(state), 1);
      chk_eq("tr_s1_count", 32'(count), 0);
      strobe_step(16'hFFFC, 8'h03, 1'b0);
      chk_eq("tr_hit_state", 32'(state), 2);
      chk_eq("tr_hit_count", 32'(count), 1);
      strobe_step(16'hFFFD, 8'h04, 1'b0);
      chk_eq("tr_count2", 32'(count), 2);
      out_ready = 1'b1;
      chk_eq("tr_head0", 32'(out_addr), 32'hFFFC);
      step();
      chk_eq("tr_head1", 32'(out_addr), 32'hFFFD);
      step();
      chk_eq("tr_empty", 32'(out_valid), 0);
      cap_en = 1'b0;
      step();

      // Post-trigger window; mode change after entry must be ignored
      trig_mode = 2'd2;
      out_ready = 1'b1;
      cap_en = 1'b1;
      step();
      chk_eq("pw_state", 32'(state), 2);
      trig_mode = 2'd0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         strobe_step(AW'(16'h0100 + i), DW'(i), 1'b1);
         if (out_valid) begin
            chk_eq("pw_entry_addr", 32'(out_addr), 32'(16'h0100 + seen));
            seen++;
         end
         if (i == 2) chk_eq("pw_state_3rd", 32'(state), 2);
         if (i == 3) chk_eq("pw_state_4th", 32'(state), 3);
      end
      step();
      chk_eq("pw_seen", 32'(seen), 4);
      chk_eq("pw_state_done", 32'(state), 3);
      chk_eq("pw_ovf", 32'(overflow), 0);
      chk_eq("pw_count", 32'(count), 0);
      cap_en = 1'b0;
      step();

      // Overflow
      trig_mode = 2'd0;
      out_ready = 1'b0;
      cap_en = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         strobe_step(AW'(16'h0200 + i), DW'(8'h40 + i), 1'b0);
      end
      chk_eq("of_count", 32'(count), 4);
      chk_eq("of_ovf", 32'(overflow), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_eq("of_drain_addr", 32'(out_addr), 32'(16'h0200 + i));
         step();
      end
      chk_eq("of_drained", 32'(count), 0);
      out_ready = 1'b0;
      cap_en = 1'b0;
      step();
      chk_eq("of_sticky", 32'(overflow), 1);
      cap_en = 1'b1;
      step();
      chk_eq("of_cleared", 32'(overflow), 0);

      // Full FIFO with simultaneous push and pop, then empty push+pop
      for (int i = 0; i < 4; i++) begin
         strobe_step(AW'(16'h0300 + i), DW'(i), 1'b1);
      end
      chk_eq("fp_full", 32'(count), 4);
      out_ready = 1'b1;
      strobe_step(16'h03AA, 8'hAA, 1'b1);
      chk_eq("fp_count", 32'(count), 4);
      chk_eq("fp_head", 32'(out_addr), 32'h0301);
      chk_eq("fp_ovf", 32'(overflow), 0);
      chk_eq("fp_d0", 32'(out_addr), 32'h0301);
      step();
      chk_eq("fp_d1", 32'(out_addr), 32'h0302);
      step();
      chk_eq("fp_d2", 32'(out_addr), 32'h0303);
      step();
      chk_eq("fp_tail", 32'(out_addr), 32'h03AA);
      chk_eq("fp_tail_data", 32'(out_data), 32'hAA);
      step();
      chk_eq("fp_empty", 32'(count), 0);
      strobe_step(16'h03BB, 8'hBB, 1'b0);
      chk_eq("ep_valid", 32'(out_valid), 1);
      chk_eq("ep_count", 32'(count), 1);
      chk_eq("ep_addr", 32'(out_addr), 32'h03BB);
      step();
      chk_eq("ep_drained", 32'(count), 0);
      cap_en = 1'b0;
      step();

      // Asynchronous reset mid-capture
      trig_mode = 2'd0;
      out_ready = 1'b0;
      cap_en = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         strobe_step(AW'(16'h0400 + i), DW'(i), 1'b1);
      end
      chk_eq("ar_count_pre", 32'(count), 3);
      chk_eq("ar_state_pre", 32'(state), 2);
      #2;
      b_rst = 1'b0;
      #1;
      chk_eq("ar_count", 32'(count), 0);
      chk_eq("ar_valid", 32'(out_valid), 0);
      chk_eq("ar_state", 32'(state), 0);
      chk_eq("ar_addr", 32'(out_addr), 0);
      cap_en = 1'b0;
      #3;
      b_rst = 1'b1;
      step();
      chk_eq("ar_after", 32'(state), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
